ahb_lite_single_master: RTL

//  AHB-Lite bus initiator that converts single requests from a simple valid/ready port into

---
 rtl/ahb_lite_single_master_pkg.sv | 23 ++
 rtl/ahb_lite_lane_mux.sv | 47 ++++
 rtl/ahb_lite_single_master.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_single_master_pkg.sv
// -----------------------------------------------------------------------------
// ahb_lite_single_master_pkg
// Purpose : AHB-Lite bus encodings shared by the single-master initiator and
//           the slaves on the same bus (transfer type, size, burst, response).
// Ports   : none (package).
// -----------------------------------------------------------------------------
package ahb_lite_single_master_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

endpackage

// File: rtl/ahb_lite_lane_mux.sv
// -----------------------------------------------------------------------------
// ahb_lite_lane_mux
// Purpose : Combinational byte-lane steering for the AHB-Lite initiator.
//           Write side: replicates right-aligned request data onto all lanes
//           and flags misaligned / illegal-size requests.
//           Read side : extracts the addressed lane(s) from HRDATA, zero-extended.
// Ports   : req_size_i/req_addr_lo_i/req_wdata_i -> lane_wdata_o, req_bad_o
//           rd_size_i/rd_addr_lo_i/hrdata_i       -> rd_data_o
// -----------------------------------------------------------------------------
module ahb_lite_lane_mux
    import ahb_lite_single_master_pkg::*;
(
    input  logic [2:0]  req_size_i,
    input  logic [1:0]  req_addr_lo_i,
    input  logic [31:0] req_wdata_i,
    output logic [31:0] lane_wdata_o,
    output logic        req_bad_o,
    input  logic [2:0]  rd_size_i,
    input  logic [1:0]  rd_addr_lo_i,
    input  logic [31:0] hrdata_i,
    output logic [31:0] rd_data_o
);

    always_comb begin
        lane_wdata_o = req_wdata_i;
        req_bad_o    = 1'b0;
        case (req_size_i)
            HSIZE_BYTE: lane_wdata_o = {4{req_wdata_i[7:0]}};
            HSIZE_HALF: begin
                lane_wdata_o = {2{req_wdata_i[15:0]}};
                req_bad_o    = req_addr_lo_i[0];
            end
            HSIZE_WORD: req_bad_o = |req_addr_lo_i;
            default:    req_bad_o = 1'b1;
        endcase
    end

    always_comb begin
        rd_data_o = hrdata_i;
        case (rd_size_i)
            HSIZE_BYTE: rd_data_o = {24'h0, hrdata_i[{rd_addr_lo_i, 3'b000} +: 8]};
            HSIZE_HALF: rd_data_o = {16'h0, hrdata_i[{rd_addr_lo_i[1], 4'b0000} +: 16]};
            default:    rd_data_o = hrdata_i;
        endcase
    end

endmodule

// File: rtl/ahb_lite_single_master.sv
// -----------------------------------------------------------------------------
// ahb_lite_single_master
// Purpose : Turns single requests on a valid/ready port into single NONSEQ
//           AHB-Lite transfers and returns read data / status on a valid/ready
//           response port. Used by debug and boot-loader logic without a CPU.
// Ports   : HCLK, HRESETn (async active-low)
//           req_valid/req_ready/req_write/req_addr/req_size/req_wdata
//           rsp_valid/rsp_ready/rsp_rdata/rsp_err/rsp_timeout
//           AHB-Lite master: HADDR HWRITE HSIZE HTRANS HWDATA HBURST HMASTLOCK
//           HPROT out; HRDATA HREADY HRESP in.
// -----------------------------------------------------------------------------
module ahb_lite_single_master
    import ahb_lite_single_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [3:0]  HPROT_VALUE    = 4'b0011
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_ADDR = 2'd1;
    localparam logic [1:0]  ST_DATA = 2'd2;
    localparam logic [1:0]  ST_RESP = 2'd3;
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q,       state_d;
    logic [31:0] haddr_q,       haddr_d;
    logic        hwrite_q,      hwrite_d;
    logic [2:0]  hsize_q,       hsize_d;
    logic [1:0]  htrans_q,      htrans_d;
    logic [31:0] hwdata_q,      hwdata_d;
    logic [31:0] wdata_q,       wdata_d;
    logic        rsp_valid_q,   rsp_valid_d;
    logic        rsp_err_q,     rsp_err_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic [31:0] rsp_rdata_q,   rsp_rdata_d;
    logic [31:0] wait_cnt_q,    wait_cnt_d;
    // Set after a forced completion: the slave may still own the data phase,
    // so no new transfer is launched until HREADY is seen high again.
    logic        stall_q,       stall_d;

    logic        accept_ok;
    logic [31:0] lane_wdata;
    logic        req_bad;
    logic [31:0] lane_rdata;

    ahb_lite_lane_mux u_lane_mux (
        .req_size_i    (req_size),
        .req_addr_lo_i (req_addr[1:0]),
        .req_wdata_i   (req_wdata),
        .lane_wdata_o  (lane_wdata),
        .req_bad_o     (req_bad),
        .rd_size_i     (hsize_q),
        .rd_addr_lo_i  (haddr_q[1:0]),
        .hrdata_i      (HRDATA),
        .rd_data_o     (lane_rdata)
    );

    assign accept_ok = (state_q == ST_IDLE) && !stall_q;
    // Forced low during reset so nothing is accepted while the bus is held.
    assign req_ready = accept_ok && HRESETn;

    always_comb begin
        state_d       = state_q;
        haddr_d       = haddr_q;
        hwrite_d      = hwrite_q;
        hsize_d       = hsize_q;
        htrans_d      = htrans_q;
        hwdata_d      = hwdata_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_rdata_d   = rsp_rdata_q;
        wait_cnt_d    = wait_cnt_q;
        stall_d       = stall_q;
        case (state_q)
            ST_IDLE: begin
                if (stall_q && HREADY) begin
                    stall_d = 1'b0;
                end
                if (req_valid && accept_ok) begin
                    if (req_bad) begin
                        // Rejected locally; the bus never sees this request.
                        state_d       = ST_RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_rdata_d   = 32'h0;
                    end else begin
                        state_d  = ST_ADDR;
                        htrans_d = HTRANS_NONSEQ;
                        haddr_d  = req_addr;
                        hwrite_d = req_write;
                        hsize_d  = req_size;
                        wdata_d  = lane_wdata;
                    end
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    state_d    = ST_DATA;
                    htrans_d   = HTRANS_IDLE;
                    wait_cnt_d = 32'h0;
                    if (hwrite_q) begin
                        hwdata_d = wdata_q;
                    end
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = (HRESP == HRESP_ERROR);
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!hwrite_q && HRESP == HRESP_OKAY) ? lane_rdata : 32'h0;
                end else if (TIMEOUT_CYCLES != 0 && wait_cnt_q == TIMEOUT_LAST) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = 32'h0;
                    stall_d       = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'h1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= ST_IDLE;
            haddr_q       <= 32'h0;
            hwrite_q      <= 1'b0;
            hsize_q       <= 3'b000;
            htrans_q      <= HTRANS_IDLE;
            hwdata_q      <= 32'h0;
            wdata_q       <= 32'h0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            wait_cnt_q    <= 32'h0;
            stall_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            haddr_q       <= haddr_d;
            hwrite_q      <= hwrite_d;
            hsize_q       <= hsize_d;
            htrans_q      <= htrans_d;
            hwdata_q      <= hwdata_d;
            wdata_q       <= wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_q       <= stall_d;
        end
    end

    assign HADDR       = haddr_q;
    assign HWRITE      = hwrite_q;
    assign HSIZE       = hsize_q;
    assign HTRANS      = htrans_q;
    assign HWDATA      = hwdata_q;
    assign HBURST      = HBURST_SINGLE;
    assign HMASTLOCK   = 1'b0;
    assign HPROT       = HPROT_VALUE;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_rdata   = rsp_rdata_q;

endmodule
